// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-port BlockRAM between an instruction-fetch port (read
// only) and a data port (read or write). The RAM has one cycle of read
// latency, so a read occupies an ACC cycle (address presented, gnt high)
// followed by a RESP cycle (rdata valid). A write finishes in its ACC cycle.
//
// Handshake: a requester raises req with its address (and write data) and
// holds them stable until it sees gnt. gnt is high for exactly the one cycle
// in which the request is presented to the RAM. If req is still high during
// the gnt cycle, that is taken as a new request. rvalid is high for one cycle
// and rdata is meaningful only while rvalid is high.
//
// A new request can be accepted from IDLE, from RESP (overlapping the read
// response), or from ACC when a write is in progress. Conflicts are resolved
// round-robin: the side that did not win last time wins.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   if_req/if_addr      fetch request and address
//   if_gnt/if_rvalid    fetch accepted / fetch read data valid
//   if_rdata            fetch read data (combinational from mem_rdata)
//   d_req/d_we/d_addr/d_wdata   data request, write flag, address, write data
//   d_gnt/d_rvalid/d_rdata      data accepted / read valid / read data
//   mem_addr/mem_wdata/mem_we   BlockRAM address, write data, write enable
//   mem_rdata           BlockRAM read data (one-cycle synchronous latency)
//   busy                high whenever the FSM is not in IDLE
//   dbg_state           current FSM state (0=IDLE, 1=ACC, 2=RESP)

module mem_port_arbiter #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req,
  input  logic [AddrWidth-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [DataWidth-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [AddrWidth-1:0] d_addr,
  input  logic [DataWidth-1:0] d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic [DataWidth-1:0] d_rdata,
  output logic [AddrWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  output logic                 mem_we,
  input  logic [DataWidth-1:0] mem_rdata,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  state_t               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_q, last_d;
  logic                 we_q, we_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;

  logic can_accept;
  logic winner;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_D;     // fetch wins the first conflict
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    winner  = OWN_IF;

    // we_q is only ever set for a data-side write, so ACC with we_q set
    // means the RAM is free again at the end of this cycle.
    can_accept = (state_q == IDLE) || (state_q == RESP) ||
                 ((state_q == ACC) && we_q);

    if (can_accept && (if_req || d_req)) begin
      if (if_req && d_req) winner = ~last_q;
      else                 winner = d_req ? OWN_D : OWN_IF;

      state_d = ACC;
      owner_d = winner;
      last_d  = winner;
      if (winner == OWN_D) begin
        addr_d  = d_addr;
        wdata_d = d_wdata;
        we_d    = d_we;
      end else begin
        addr_d  = if_addr;
        we_d    = 1'b0;     // wdata keeps its last value; fetch never writes
      end
    end else begin
      case (state_q)
        ACC:     state_d = we_q ? IDLE : RESP;
        RESP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (state_d == IDLE) we_d = 1'b0;
    end
  end

  // All outputs decode registered state, so gnt/rvalid/mem_we are clean
  // one-cycle pulses and are forced low immediately by reset.
  assign if_gnt    = (state_q == ACC)  && (owner_q == OWN_IF);
  assign d_gnt     = (state_q == ACC)  && (owner_q == OWN_D);
  assign if_rvalid = (state_q == RESP) && (owner_q == OWN_IF);
  assign d_rvalid  = (state_q == RESP) && (owner_q == OWN_D);
  assign mem_we    = (state_q == ACC)  && (owner_q == OWN_D) && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 16;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;
  logic          busy;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  // expected RAM writes, packed as {addr, data}
  logic [AW+DW-1:0] exp_q[$];

  mem_port_arbiter #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BlockRAM model: synchronous write, one-cycle read latency
  logic [DW-1:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // scoreboard for RAM writes
  always @(negedge clk) begin
    if (reset && mem_we) begin
      if (exp_q.size() == 0) check("wr_unexpected", 64'd1, 64'd0);
      else check("wr_addr_data", {mem_addr, mem_wdata}, exp_q.pop_front());
    end
  end

  // driver tasks: everything is driven and sampled at the falling edge
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic do_reset();
    reset = 0;
    cyc(); cyc();
    reset = 1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"},  {if_gnt, d_gnt}, 2'b00);
    check({tag, "_rv"},   {if_rvalid, d_rvalid}, 2'b00);
    check({tag, "_we"},   mem_we, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_st"},   dbg_state, 2'd0);
    check({tag, "_addr"}, mem_addr, 16'h0);
    check({tag, "_wd"},   mem_wdata, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = '0;
    ram[8'h10] = 32'hD300_0000;
    idle_inputs();
    reset = 0;
    cyc();
    check_reset_vals("rst");
    cyc();
    reset = 1;

    // fetch read
    if_req = 1; if_addr = 16'h0010;
    cyc();
    check("f_gnt",  {if_gnt, d_gnt}, 2'b10);
    check("f_addr", mem_addr, 16'h0010);
    check("f_we",   mem_we, 1'b0);
    check("f_busy", busy, 1'b1);
    if_req = 0;
    cyc();
    check("f_rv",    {if_rvalid, d_rvalid}, 2'b10);
    check("f_rdata", if_rdata, 32'hD300_0000);
    check("f_gnt2",  {if_gnt, d_gnt}, 2'b00);
    cyc();
    check("f_idle", {busy, if_rvalid}, 2'b00);

    // data write
    d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 32'hCAFE_BABE;
    exp_q.push_back({16'h0020, 32'hCAFE_BABE});
    cyc();
    check("w_gnt", {if_gnt, d_gnt, mem_we}, 3'b011);
    check("w_addr", mem_addr, 16'h0020);
    check("w_data", mem_wdata, 32'hCAFE_BABE);
    idle_inputs();
    cyc();
    check("w_done", {mem_we, d_rvalid, if_rvalid, busy}, 4'b0000);

    // conflict after reset: grants alternate IF, D, IF, D
    do_reset();
    if_req = 1; if_addr = 16'h0010;
    d_req = 1; d_we = 0; d_addr = 16'h0020;
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i % 2 == 0) begin
        check("c_gnt_if", {if_gnt, d_gnt}, 2'b10);
        check("c_addr_if", mem_addr, 16'h0010);
      end else begin
        check("c_gnt_d", {if_gnt, d_gnt}, 2'b01);
        check("c_addr_d", mem_addr, 16'h0020);
      end
      if (i == 3) idle_inputs();
      cyc();
      if (i % 2 == 0) begin
        check("c_rv_if", {if_rvalid, d_rvalid}, 2'b10);
        check("c_rd_if", if_rdata, 32'hD300_0000);
      end else begin
        check("c_rv_d", {if_rvalid, d_rvalid}, 2'b01);
        check("c_rd_d", d_rdata, 32'hCAFE_BABE);
      end
    end
    cyc();
    check("c_idle", busy, 1'b0);

    // back-to-back writes with req held
    d_req = 1; d_we = 1;
    d_addr = 16'h0001; d_wdata = 32'hA000_0001;
    exp_q.push_back({16'h0001, 32'hA000_0001});
    exp_q.push_back({16'h0002, 32'hA000_0002});
    exp_q.push_back({16'h0003, 32'hA000_0003});
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("b_gnt", {d_gnt, mem_we}, 2'b11);
      check("b_addr", mem_addr, 16'(i));
      if (i == 3) idle_inputs();
      else begin
        d_addr = 16'(i + 1); d_wdata = 32'hA000_0000 + 32'(i + 1);
      end
    end
    cyc();
    check("b_done", {d_gnt, mem_we, busy}, 3'b000);
    check("b_ram3", ram[3], 32'hA000_0003);

    // reset during the ACC cycle of a fetch read
    if_req = 1; if_addr = 16'h0010;
    cyc();
    check("r_gnt", if_gnt, 1'b1);
    idle_inputs();
    #1 reset = 0;
    #1 check_reset_vals("r_async");
    cyc(); cyc();
    reset = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("r_no_rv", {if_rvalid, d_rvalid, busy}, 3'b000);
    end

    // reset during the ACC cycle of a write
    d_req = 1; d_we = 1; d_addr = 16'h0040; d_wdata = 32'h5555_AAAA;
    exp_q.push_back({16'h0040, 32'h5555_AAAA});
    cyc();
    check("rw_we", mem_we, 1'b1);
    idle_inputs();
    #1 reset = 0;
    #1 check("rw_we_drop", mem_we, 1'b0);
    cyc(); cyc();
    reset = 1;
    cyc();
    check("rw_ram", ram[8'h40], 32'h0);

    // write then read the same address
    d_req = 1; d_we = 1; d_addr = 16'h0030; d_wdata = 32'h1234_5678;
    exp_q.push_back({16'h0030, 32'h1234_5678});
    cyc();
    check("wr_gnt", {d_gnt, mem_we}, 2'b11);
    idle_inputs();
    cyc();
    d_req = 1; d_we = 0; d_addr = 16'h0030;
    cyc();
    check("rd_gnt", {d_gnt, mem_we}, 2'b10);
    idle_inputs();
    cyc();
    check("rd_rv", {if_rvalid, d_rvalid}, 2'b01);
    check("rd_data", d_rdata, 32'h1234_5678);
    cyc();
    check("rd_idle", busy, 1'b0);

    check("wq_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Parameters
REQ-001 The block SHALL have parameter DataWidth, default 32, meaning the data bus width.
REQ-002 The block SHALL have parameter AddrWidth, default 16, meaning the address bus width.

Interface
REQ-003 The block SHALL have port clk, input, width 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1: asynchronous, active-low reset.
REQ-005 The block SHALL have port if_req, input, width 1: instruction-fetch read request.
REQ-006 The block SHALL have port if_addr, input, width AddrWidth: fetch address.
REQ-007 The block SHALL have port if_gnt, output, width 1: fetch request accepted.
REQ-008 The block SHALL have port if_rvalid, output, width 1: fetch read data valid.
REQ-009 The block SHALL have port if_rdata, output, width DataWidth: fetch read data.
REQ-010 The block SHALL have port d_req, input, width 1: data-side request.
REQ-011 The block SHALL have port d_we, input, width 1: data-side write (1) or read (0).
REQ-012 The block SHALL have port d_addr, input, width AddrWidth: data-side address.
REQ-013 The block SHALL have port d_wdata, input, width DataWidth: data-side write data.
REQ-014 The block SHALL have port d_gnt, output, width 1: data-side request accepted.
REQ-015 The block SHALL have port d_rvalid, output, width 1: data-side read data valid.
REQ-016 The block SHALL have port d_rdata, output, width DataWidth: data-side read data.
REQ-017 The block SHALL have port mem_addr, output, width AddrWidth: BlockRAM address.
REQ-018 The block SHALL have port mem_wdata, output, width DataWidth: BlockRAM write data.
REQ-019 The block SHALL have port mem_we, output, width 1: BlockRAM write enable.
REQ-020 The block SHALL have port mem_rdata, input, width DataWidth: BlockRAM read data, one-cycle synchronous latency.
REQ-021 The block SHALL have port busy, output, width 1: high whenever the state is not IDLE.

Function
REQ-022 The block SHALL implement FSM states IDLE, ACC and RESP.
REQ-023 An accept edge SHALL be any rising edge where the state is IDLE, RESP, or ACC with a write in progress, and at least one request is high.
REQ-024 At an accept edge, the block SHALL latch the winner's address (plus d_we and d_wdata for the data side) into mem_addr/mem_wdata, set the owner, and enter ACC.
REQ-025 The fetch side SHALL always be a read.
REQ-026 The winner's gnt SHALL be a registered pulse, high for exactly the ACC cycle.
REQ-027 At a non-accept rising edge, the block SHALL go ACC-read->RESP, ACC-write->IDLE and RESP->IDLE.
REQ-028 In ACC, mem_we SHALL equal the latched d_we for the data owner and 0 for the fetch owner; mem_we SHALL be 0 in every other state.
REQ-029 In RESP, the owner's rvalid SHALL be high and the other side's rvalid SHALL be low.
REQ-030 Read latency SHALL be two cycles: req sampled at edge T, gnt high T+1, rvalid high T+2.
REQ-031 if_rdata and d_rdata SHALL both be driven combinationally from mem_rdata, and are meaningful only while the corresponding rvalid is high.
REQ-032 A requester SHALL hold req and its address/data stable until it sees gnt.
REQ-033 req still high during the gnt cycle SHALL be treated as a new request.
REQ-034 When only one request is high at an accept edge, that requester SHALL win.
REQ-035 When both requests are high at an accept edge, the side opposite last_owner SHALL win, and last_owner SHALL update to the winner on every accept.
REQ-036 A read's RESP cycle SHALL overlap the next request's ACC cycle, giving back-to-back reads a throughput of one access per two cycles.
REQ-037 Back-to-back writes SHALL sustain one access per cycle.
REQ-038 In IDLE, mem_addr and mem_wdata SHALL hold their last latched values.
REQ-039 Address arithmetic SHALL be pass-through only, with no wrap, offset or range check.

Reset
REQ-040 reset low SHALL asynchronously force: state=IDLE, last_owner=DATA (fetch wins the first conflict), mem_addr=0, mem_wdata=0, mem_we=0, if_gnt=0, d_gnt=0, if_rvalid=0, d_rvalid=0, busy=0.
REQ-041 On reset mid-operation, a pending read SHALL be dropped with no rvalid after reset release, and a write in ACC SHALL have mem_we deasserted immediately.
REQ-042 After reset release, the first accept SHALL be possible at the first rising edge with reset high.

Verification
REQ-043 Fetch read: if_req=1, if_addr=0x0010, memory[0x10]=0xD3000000 -> if_gnt high cycle 1, mem_addr=0x0010, if_rvalid high cycle 2 with if_rdata=0xD3000000.
REQ-044 Data write: d_req=1, d_we=1, d_addr=0x0020, d_wdata=0xCAFEBABE -> d_gnt and mem_we high for one cycle with mem_addr=0x0020, mem_wdata=0xCAFEBABE, no rvalid, then IDLE.
REQ-045 Conflict after reset: both reqs high at the same edge, reads -> fetch wins first; with both still high at the RESP edge -> data wins next; grants alternate IF, D, IF, D.
REQ-046 Back-to-back: three d writes with req held continuously -> d_gnt high three consecutive cycles with addresses 0x1, 0x2, 0x3 written in order.
REQ-047 Reset mid-read: assert reset during ACC of a fetch read -> outputs take reset values immediately, and no if_rvalid occurs after release.
REQ-048 Write-then-read same address 0x0030: write 0x12345678 then read -> d_rvalid returns 0x12345678.
